cmp_seq_nbit: RTL
=================

Name: cmp_seq_nbit

Overview:
- Parametrised, multi-cycle magnitude comparator; successor to the fixed 2-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, in unsigned or two's-complement signed mode.
- Terminates early on the first differing chunk and returns registered gt/lt/eq through a valid/ready handshake.
- Sits between an operand producer and a result consumer in datapath and control blocks.

Parameters:
- WIDTH, 16, operand width in bits; must be ≥ 2.
- CHUNK, 4, bits compared per cycle; must satisfy WIDTH % CHUNK == 0.
- NCHUNK, WIDTH/CHUNK, derived local constant; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair and mode are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare; 0 = unsigned compare.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- gt  out  1  A > B.
- lt  out  1  A < B.
- eq  out  1  A == B.
- cycles  out  $clog2(NCHUNK+1)  number of chunk-compare cycles used for this result (1..NCHUNK).

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; gt=lt=eq=0; cycles=0; operand registers cleared.
- FSM states: IDLE, RUN, DONE. in_ready=1 only in IDLE.
- IDLE:
  - On in_valid&in_ready, capture a and b into internal registers, idx=NCHUNK-1, cnt=0, then go to RUN.
  - When signed_mode=1, the captured MSB of both operands is inverted (offset-binary), so every later compare is unsigned.
- RUN, each cycle:
  - Compare chunk idx of A against chunk idx of B (unsigned, CHUNK bits) and increment cnt.
  - Chunks differ: gt/lt set from that chunk compare, eq=0, cycles=cnt+1, go to DONE.
  - Chunks equal and idx==0: eq=1, gt=lt=0, cycles=NCHUNK, go to DONE.
  - Otherwise: decrement idx and stay in RUN.
- DONE:
  - out_valid=1; gt/lt/eq/cycles stay stable.
  - On out_ready, go to IDLE and drop out_valid the following cycle.
  - Results stay valid indefinitely while out_ready=0.
- Latency: acceptance edge at cycle 0; out_valid rises k+1 edges later, where k is the 1-based position of the first differing chunk from the MSB end (k=NCHUNK if the operands are equal). Minimum 2, maximum NCHUNK+1.
- No throughput overlap: a new operand pair is accepted no earlier than the cycle after the result handshake completes.
- Result flags:
  - Exactly one of gt/lt/eq is 1 whenever out_valid=1.
  - All flags are 0 outside DONE; they clear on leaving DONE.
- Input stability: a, b and signed_mode are sampled only at acceptance. Later changes have no effect on the comparison in progress.
- Boundaries:
  - CHUNK==WIDTH gives single-cycle compare, latency 2.
  - Signed extremes (most-negative vs most-positive) must resolve correctly in the top chunk.
- Reset mid-RUN or mid-DONE aborts immediately to reset values. The operation is lost and the result is not delivered.
- in_valid asserted outside IDLE is ignored. The producer must hold it until in_ready.

Decomposition:
- Shared package cmp_pkg:
  - state enum cmp_state_t {IDLE, RUN, DONE};
  - result struct {gt, lt, eq};
  - helper function for the NCHUNK/WIDTH legality check, used in an elaboration-time assertion.
- One sub-module, cmp_chunk:
  - purely combinational CHUNK-bit unsigned compare producing gt/lt/eq;
  - the parametrised generalisation of the 2-bit comparator, instantiated once on the muxed chunk.

Test Plan:
- Unsigned early exit (WIDTH=16, CHUNK=4): a=0x8000, b=0x7FFF, signed_mode=0 → gt=1, lt=0, eq=0, cycles=1, out_valid 2 cycles after accept.
- Signed compare: a=0x8000 (-32768), b=0x7FFF, signed_mode=1 → lt=1, cycles=1; a=0xFFFF (-1), b=0xFFFE (-2) → gt=1, cycles=4.
- Full-depth equal: a=b=0x1234 → eq=1, gt=lt=0, cycles=4, out_valid 5 cycles after accept.
- Backpressure: result a=0x0010, b=0x0020 (lt=1, cycles=3); hold out_ready=0 for 10 cycles → flags stable and in_ready=0 throughout; out_ready=1 → IDLE next cycle, in_ready=1.
- Reset mid-operation: accept a=0x0001, b=0x0002, pulse rst_n low during RUN → out_valid never rises, all outputs 0, in_ready=1; next pair a=5, b=5 → eq=1.
- Input instability and CHUNK=WIDTH variant: change a/b after accept → result reflects the captured values only; with CHUNK=16, a=3, b=9 → lt=1, cycles=1, latency 2.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and configuration check for the sequential magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  // Legal when the operand splits into whole chunks of at least one bit.
  function automatic bit cfg_ok(input int width, input int chunk);
    return (width >= 2) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module cmp_chunk
  import cmp_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output cmp_res_t         res
);

  assign res.gt = (a > b);
  assign res.lt = (a < b);
  assign res.eq = (a == b);

endmodule

// File: rtl/cmp_seq_nbit.sv
// Multi-cycle MSB-first magnitude comparator with early exit and valid/ready result.
module cmp_seq_nbit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  a,
  input  logic [WIDTH-1:0]                  b,
  input  logic                              signed_mode,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              gt,
  output logic                              lt,
  output logic                              eq,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]  cycles
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("cmp_seq_nbit: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  cmp_state_t       state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cycles_r;
  cmp_res_t         res_r;
  logic             out_valid_r;
  logic [CHUNK-1:0] ca, cb;
  cmp_res_t         cr;

  if (NCHUNK == 1) begin : g_one
    assign ca = a_r;
    assign cb = b_r;
  end else begin : g_mux
    logic [NCHUNK-1:0][CHUNK-1:0] ach, bch;
    assign ach = a_r;
    assign bch = b_r;
    assign ca  = ach[idx];
    assign cb  = bch[idx];
  end

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a   (ca),
    .b   (cb),
    .res (cr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      idx         <= '0;
      cnt         <= '0;
      cycles_r    <= '0;
      res_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          a_r   <= signed_mode ? {~a[WIDTH-1], a[WIDTH-2:0]} : a;
          b_r   <= signed_mode ? {~b[WIDTH-1], b[WIDTH-2:0]} : b;
          idx   <= IW'(NCHUNK - 1);
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (!cr.eq) begin
            res_r    <= cr;
            cycles_r <= cnt + 1'b1;
            state    <= DONE;
          end else if (idx == '0) begin
            res_r    <= '{gt: 1'b0, lt: 1'b0, eq: 1'b1};
            cycles_r <= CW'(NCHUNK);
            state    <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          // Result registers settle on DONE entry; valid follows one edge later.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            res_r       <= '0;
            cycles_r    <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_r;
  assign gt        = res_r.gt;
  assign lt        = res_r.lt;
  assign eq        = res_r.eq;
  assign cycles    = cycles_r;

endmodule
